// File: rtl/fx_widen_accum.sv
// Widens signed fixed-point samples and accumulates blocks of N_ACC samples with
// saturation. Each finished block sum is presented on a registered valid/ready output.
module fx_widen_accum #(
    parameter int NB_XI  = 9,
    parameter int NBF_XI = 7,
    parameter int NB_XO  = 17,
    parameter int NBF_XO = 10,
    parameter int N_ACC  = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NB_XI-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [NB_XO-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sat,
    output logic             o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // o_ready/o_valid are registered and never depend combinationally on i_valid/i_ready.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int K     = NBF_XO - NBF_XI;
    localparam int CNT_W = $clog2(N_ACC + 1);
    localparam logic [NB_XO-1:0] MAX_VAL = {1'b0, {(NB_XO-1){1'b1}}};
    localparam logic [NB_XO-1:0] MIN_VAL = {1'b1, {(NB_XO-1){1'b0}}};

    state_t             r_state, w_state_nxt;
    logic [NB_XO-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_sticky, w_sticky_nxt;
    logic               r_ready, w_ready_nxt;
    logic               r_valid, w_valid_nxt;
    logic [NB_XO-1:0]   r_data, w_data_nxt;
    logic               r_sat, w_sat_nxt;

    logic signed [NB_XO-1:0] w_ext;
    logic signed [NB_XO-1:0] w_wide;
    logic [NB_XO:0]          w_sum;
    logic                    w_ovf;
    logic [NB_XO-1:0]        w_clamped;
    logic                    w_accept;

    assign w_ext  = NB_XO'($signed(i_data));
    assign w_wide = w_ext <<< K;
    // One guard bit: the sum cannot wrap, so the top two bits disagree exactly on overflow.
    assign w_sum  = {r_acc[NB_XO-1], r_acc} + {w_wide[NB_XO-1], w_wide};
    assign w_ovf  = w_sum[NB_XO] ^ w_sum[NB_XO-1];
    assign w_clamped = w_ovf ? (w_sum[NB_XO] ? MIN_VAL : MAX_VAL) : w_sum[NB_XO-1:0];
    assign w_accept  = i_valid & r_ready & (r_state == ST_ACCUM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sticky <= w_sticky_nxt;
            r_ready  <= w_ready_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
            r_sat    <= w_sat_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_sticky_nxt = r_sticky;
        w_ready_nxt  = r_ready;
        w_valid_nxt  = r_valid;
        w_data_nxt   = r_data;
        w_sat_nxt    = r_sat;
        case (r_state)
            ST_ACCUM: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_acc_nxt    = w_clamped;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    w_sticky_nxt = r_sticky | w_ovf;
                    if (r_cnt == CNT_W'(N_ACC - 1)) begin
                        w_state_nxt = ST_HOLD;
                        w_ready_nxt = 1'b0;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_clamped;
                        w_sat_nxt   = r_sticky | w_ovf;
                    end
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    w_state_nxt  = ST_ACCUM;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_sticky_nxt = 1'b0;
                    w_valid_nxt  = 1'b0;
                    w_ready_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_sat       = r_sat;
    assign o_dbg_state = r_state;

endmodule

// File: doc/fx_widen_accum.md
FX_WIDEN_ACCUM -- requirements
Module: fx_widen_accum

Interface
REQ-001 The block SHALL have parameter NB_XI, default 9, meaning the narrow input sample width in bits (signed).
REQ-002 The block SHALL have parameter NBF_XI, default 7, meaning the number of fraction bits of the input.
REQ-003 The block SHALL have parameter NB_XO, default 17, meaning the wide accumulator/output width in bits (signed).
REQ-004 The block SHALL have parameter NBF_XO, default 10, meaning the number of fraction bits of the output.
REQ-005 The block SHALL have parameter N_ACC, default 64, meaning the number of samples per accumulation block.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-008 The block SHALL have port i_data, input, NB_XI bits: the signed narrow sample in format (NB_XI,NBF_XI).
REQ-009 The block SHALL have port i_valid, input, 1 bit: asserted when i_data is valid.
REQ-010 The block SHALL have port o_ready, output, 1 bit: asserted when the block can accept a sample.
REQ-011 The block SHALL have port o_data, output, NB_XO bits: the signed block sum in format (NB_XO,NBF_XO).
REQ-012 The block SHALL have port o_valid, output, 1 bit: asserted when o_data holds a completed block sum.
REQ-013 The block SHALL have port i_ready, input, 1 bit: asserted when the downstream consumer accepts o_data.
REQ-014 The block SHALL have port o_sat, output, 1 bit: asserted when saturation occurred at least once during the block now presented.

Function
REQ-015 Parameters SHALL satisfy NBF_XO>=NBF_XI, (NB_XO-NBF_XO)>=(NB_XI-NBF_XI), and N_ACC>=1; any other setting is unsupported.
REQ-016 Widening SHALL sign-extend i_data to NB_XO bits and shift it left by K=NBF_XO-NBF_XI (K=3 by default); this step is exact and never rounds or saturates.
REQ-017 A sample SHALL be accepted on a rising edge only when i_valid=1 and o_ready=1; otherwise i_data SHALL be ignored.
REQ-018 On each accepted sample, acc SHALL become sat(acc + widened sample), clamped to [-2^(NB_XO-1), 2^(NB_XO-1)-1], i.e. [-65536, 65535] by default.
REQ-019 The sum SHALL be computed with at least NB_XO+1 bits so that it never wraps before it is clamped.
REQ-020 An internal sticky flag SHALL set whenever a clamp occurs and SHALL stay set until the block is handed off.
REQ-021 The FSM SHALL have two states: ACCUM, with o_ready=1 and o_valid=0, and HOLD, with o_ready=0 and o_valid=1.
REQ-022 In ACCUM, a sample counter SHALL increment on each accepted sample; when the N_ACC-th sample is accepted, the FSM SHALL enter HOLD on that same edge.
REQ-023 On entry to HOLD, o_data SHALL equal the final saturated acc (including the N_ACC-th sample) and o_sat SHALL equal the sticky flag, so o_valid rises one cycle after the last accepted sample.
REQ-024 In HOLD, o_data and o_sat SHALL stay stable until a handoff; i_valid SHALL be ignored.
REQ-025 In HOLD with i_ready=1, the handoff SHALL complete on that edge: the FSM returns to ACCUM, and acc, the counter and the sticky flag clear to 0.
REQ-026 The first sample of the next block SHALL be accepted no earlier than the cycle after a handoff.
REQ-027 o_ready, o_valid, o_data and o_sat SHALL be register outputs; there SHALL be no combinational path from i_valid or i_ready to any output.
REQ-028 Once saturated, acc SHALL respond normally to later samples of the opposite sign (no wrap, no lock-up).

Reset
REQ-029 While i_rst_n=0, the block SHALL hold acc=0, counter=0, sticky flag=0, state=ACCUM, o_ready=0, o_valid=0, o_data=0 and o_sat=0, independent of i_clk.
REQ-030 o_ready SHALL rise on the first i_clk rising edge after i_rst_n is released.
REQ-031 Reset asserted mid-block or during HOLD SHALL discard all partial or pending results.

Verification
REQ-032 The bench SHALL drive 64 samples of i_data=+1 (raw 0x001) and require o_data=512, o_sat=0, with o_valid rising one cycle after the 64th accept.
REQ-033 The bench SHALL drive 64 samples of 255 and require the sum to clamp at the 33rd sample (32*2040=65280, then 67320 clamps); required response: o_data=65535, o_sat=1.
REQ-034 The bench SHALL drive 32 samples of -256 followed by 32 samples of 0 and require o_data=-65536 with o_sat=0 (exact minimum, no clamp); with 33 samples of -256, o_sat=1 and o_data=-65536.
REQ-035 The bench SHALL drive 33 samples of 255 (acc clamps to 65535), then 1 sample of -1, then 30 samples of 0, and require o_data=65527 and o_sat=1.
REQ-036 The bench SHALL drive alternating 255/-256 samples with i_valid randomly gapped and require o_data=-256, o_sat=0; it SHALL then hold i_ready=0 for 10 cycles and require o_valid=1, o_ready=0, o_data stable and i_valid ignored.
REQ-037 The bench SHALL assert i_rst_n=0 after 20 accepted samples, release it, then drive 64 samples of +1, and require o_data=512 and o_sat=0.
